tick_period_meter: RTL and testbench
====================================

// Module: tick_period_meter
// PURPOSE
//  Recovers the divider setting of a periodic tick stream: measures the en-qualified
//  cycle count between two successive tick pulses and reports it as N (period - 1).
//  Inverse of the tick generator: ticks from a generator loaded with N read back N.
//  Sits downstream of tick sources and on external timing inputs for self-check/calibration.
// PARAMETERS
//  WIDTH  5  width of internal counter and of N_out; saturates at 2**WIDTH-1
// PORTS
//  clk       in   1      clock
//  rst       in   1      reset, asynchronous, active-high
//  en        in   1      count/sample enable; en=0 freezes counter and ignores tick_in
//  start     in   1      1-cycle pulse: arm a new measurement
//  tick_in   in   1      tick stream; each cycle sampled high (with en=1) is one event
//  N_out     out  WIDTH  measured N = period-1, held until the next result
//  valid     out  1      1-cycle pulse when N_out updates
//  busy      out  1      high in ARMED or MEASURE
//  overflow  out  1      period exceeded 2**WIDTH cycles; N_out is saturated
// BEHAVIOUR
//  - Reset (async): state IDLE, count=0, N_out=0, valid=0, overflow=0.
//  - States: IDLE, ARMED, MEASURE, DONE. busy = (ARMED|MEASURE), registered.
//  - event = tick_in & en (after optional synchroniser). start works regardless of en.
//  - start in any state: -> ARMED, count<=0, overflow<=0; start beats a same-cycle event.
//  - ARMED: on event -> MEASURE, count<=0.
//  - MEASURE, en=1, no event: count<=count+1; at all-ones it holds and overflow<=1.
//  - MEASURE, event: N_out<=count, valid<=1 (next cycle, one cycle only) -> DONE.
//    Back-to-back events (tick_in high every cycle) give N_out=0.
//  - MEASURE, en=0: count and state hold.
//  - DONE: N_out and overflow held; events ignored; only start leaves DONE.
//  - Latency: valid rises one clk after the closing event is sampled.
//  - Reset mid-measurement aborts immediately; no valid is produced.
//  - Example: generator N=2, en=1: events at t, t+3 -> valid at t+4, N_out=2.
// CONFIGURATION
//  TICK_METER_SYNC_EN defined: tick_in passes through a 2-flop synchroniser
//   (reset to 0) before event detection, so tick_in may be asynchronous;
//   valid is 2 cycles later, measured N unchanged.
//  Not defined: tick_in used directly and must be synchronous to clk.
// STRUCTURE
//  - tick_meter_pkg: typedef enum logic [1:0] meter_state_t {IDLE, ARMED, MEASURE, DONE}.
//  - Sub-module sync2 (2-flop synchroniser, async active-high reset), instantiated
//    only under TICK_METER_SYNC_EN.
//  - Body: one state register, one counter with saturation, output registers.
// TESTING
//  1. Tick generator N=2, en=1, start -> valid pulse, N_out=2, overflow=0, busy falls.
//  2. Generator N=0 (tick high every cycle), start -> N_out=0 one cycle after 2nd event.
//  3. WIDTH=5, events 40 cycles apart -> N_out=31, overflow=1; next start clears overflow.
//  4. Generator N=4, en toggled 1/0 each cycle on both blocks -> N_out=4.
//  5. rst asserted in MEASURE -> outputs 0 at once, no valid; start+event same cycle in
//     ARMED -> stays ARMED, measurement starts at the next event.
//  6. start pulse in MEASURE after 7 counts -> re-arms; next pair 3 cycles apart -> N_out=2.

Source files
------------

// File: rtl/tick_meter_pkg.sv
// Shared types for the tick period meter: the measurement state encoding and
// the default counter width.
package tick_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } meter_state_t;

  localparam int unsigned DEFAULT_WIDTH = 5;

endpackage : tick_meter_pkg

// File: rtl/tick_period_meter_sync2.sv
// Two-flop synchroniser for a single asynchronous level, cleared by an
// asynchronous active-high reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : sync2

// File: rtl/tick_period_meter.sv
// Measures the en-qualified cycle count between two successive ticks and
// reports it as N = period-1. Define TICK_METER_SYNC_EN to synchronise tick_in.
module tick_period_meter
  import tick_meter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             tick_in,
  output logic [WIDTH-1:0] N_out,
  output logic             valid,
  output logic             busy,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic tick_s;

`ifdef TICK_METER_SYNC_EN
  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (tick_in),
    .q   (tick_s)
  );
`else
  assign tick_s = tick_in;
`endif

  logic evt;
  assign evt = tick_s & en;

  meter_state_t     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    count_d = count_q;
    n_d     = n_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;

    // start wins over a same-cycle event in every state.
    if (start) begin
      state_d = ARMED;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ARMED: begin
          if (evt) begin
            state_d = MEASURE;
            count_d = '0;
          end
        end
        MEASURE: begin
          if (evt) begin
            n_d     = count_q;
            valid_d = 1'b1;
            state_d = DONE;
          end else if (en) begin
            if (count_q == CNT_MAX) ovf_d = 1'b1;
            else                    count_d = count_q + CNT_ONE;
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == ARMED) || (state_d == MEASURE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      n_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
      state_q <= state_d;
      count_q <= count_d;
      n_q     <= n_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign N_out    = n_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule : tick_period_meter

// File: tb/tb_tick_period_meter.sv
// Directed self-checking bench for tick_period_meter (WIDTH=5); adapts its
// tick-to-event delay when TICK_METER_SYNC_EN is defined.
module tb_tick_period_meter;

`ifdef TICK_METER_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic       tick_in = 1'b0;
  logic [4:0] n_out;
  logic       valid;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int v0;

  always #5 clk = ~clk;

  tick_period_meter #(.WIDTH(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .tick_in  (tick_in),
    .N_out    (n_out),
    .valid    (valid),
    .busy     (busy),
    .overflow (overflow)
  );

  // Independent tally of valid pulses, used to prove that none appeared.
  always @(negedge clk) if (valid === 1'b1) valid_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_tick();
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_async_nout", 32'(n_out), 0);
    check("rst_async_valid", 32'(valid), 0);
    check("rst_async_busy", 32'(busy), 0);
    check("rst_async_ovf", 32'(overflow), 0);
    step();
    step();
    rst = 1'b0;
    en  = 1'b1;
    step();
    check("idle_busy", 32'(busy), 0);

    // 1: generator N=2, ticks three cycles apart
    do_start();
    check("t1_busy_armed", 32'(busy), 1);
    do_tick();
    step();
    step();
    do_tick();
    repeat (SD) step();
    check("t1_valid", 32'(valid), 1);
    check("t1_nout", 32'(n_out), 2);
    check("t1_ovf", 32'(overflow), 0);
    check("t1_busy_fell", 32'(busy), 0);
    step();
    check("t1_valid_one_cycle", 32'(valid), 0);
    check("t1_nout_held", 32'(n_out), 2);
    do_tick();
    repeat (SD + 2) step();
    check("t1_done_ignores_events", 32'(valid_cnt), 1);

    // 2: tick high every cycle
    do_start();
    tick_in = 1'b1;
    step();
    step();
    tick_in = 1'b0;
    repeat (SD) step();
    check("t2_valid", 32'(valid), 1);
    check("t2_nout", 32'(n_out), 0);

    // 3: events 40 apart saturate; then exactly 32 apart is the largest clean period
    do_start();
    do_tick();
    repeat (39) step();
    do_tick();
    repeat (SD) step();
    check("t3_valid", 32'(valid), 1);
    check("t3_nout_sat", 32'(n_out), 31);
    check("t3_ovf", 32'(overflow), 1);
    step();
    check("t3_ovf_held_done", 32'(overflow), 1);
    do_start();
    check("t3_start_clears_ovf", 32'(overflow), 0);
    do_tick();
    repeat (31) step();
    do_tick();
    repeat (SD) step();
    check("t3b_valid", 32'(valid), 1);
    check("t3b_nout_31", 32'(n_out), 31);
    check("t3b_no_ovf", 32'(overflow), 0);

    // 4: en toggles every cycle; events on the 0th and 5th enabled cycle
    do_start();
    for (int i = 0; i <= 10 + SD; i++) begin
      en      = (i % 2 == 0);
      tick_in = (i == 0) || (i == 1) || (i == 10);
      step();
    end
    en      = 1'b1;
    tick_in = 1'b0;
    check("t4_valid", 32'(valid), 1);
    check("t4_nout", 32'(n_out), 4);

    // 5a: reset mid-measurement aborts at once
    do_start();
    do_tick();
    repeat (SD + 3) step();
    check("t5_busy_measure", 32'(busy), 1);
    v0 = valid_cnt;
    #2 rst = 1'b1;
    #1;
    check("t5_rst_nout", 32'(n_out), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_valid", 32'(valid), 0);
    check("t5_rst_ovf", 32'(overflow), 0);
    step();
    rst = 1'b0;
    do_tick();
    step();
    do_tick();
    repeat (SD + 3) step();
    check("t5_no_valid_after_rst", 32'(valid_cnt - v0), 0);
    check("t5_idle_after_rst", 32'(busy), 0);

    // 5b: start and event in the same cycle while ARMED
    do_start();
    v0 = valid_cnt;
    tick_in = 1'b1;
    if (SD == 0) start = 1'b1;
    step();
    tick_in = 1'b0;
    start   = 1'b0;
    if (SD > 0) begin
      repeat (SD - 1) step();
      do_start();
    end
    check("t5b_still_armed", 32'(busy), 1);
    repeat (3) step();
    do_tick();
    step();
    step();
    do_tick();
    repeat (SD) step();
    check("t5b_no_early_valid", 32'(valid_cnt - v0), 0);
    check("t5b_valid", 32'(valid), 1);
    check("t5b_nout", 32'(n_out), 2);

    // 6: start during MEASURE re-arms
    do_start();
    do_tick();
    repeat (SD + 7) step();
    do_start();
    check("t6_rearmed_busy", 32'(busy), 1);
    v0 = valid_cnt;
    do_tick();
    step();
    step();
    do_tick();
    repeat (SD) step();
    check("t6_no_stale_valid", 32'(valid_cnt - v0), 0);
    check("t6_valid", 32'(valid), 1);
    check("t6_nout", 32'(n_out), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_tick_period_meter
